// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// FSM states, instruction classes, opcode/funct fields and ALU function codes.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } iclass_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;
    localparam logic [5:0] ALU_BLTZ = 6'b111000;
    localparam logic [5:0] ALU_BGEZ = 6'b111001;
    localparam logic [5:0] ALU_J    = 6'b111010;
    localparam logic [5:0] ALU_JR   = 6'b111011;
    localparam logic [5:0] ALU_BEQ  = 6'b111100;
    localparam logic [5:0] ALU_BNE  = 6'b111101;
    localparam logic [5:0] ALU_BLEZ = 6'b111110;
    localparam logic [5:0] ALU_BGTZ = 6'b111111;

endpackage

// File: rtl/mips_func_decode.sv
// Combinational instruction decoder: maps an instruction word to the ALU
// function code, instruction class, operand/destination selects and an illegal flag.
module mips_func_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [5:0]  o_alu_func,
    output iclass_t     o_class,
    output logic        o_src_imm,
    output logic        o_regdst_rd,
    output logic        o_illegal
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_fn;
    logic       w_unused_fields;

    assign w_op = i_ir[31:26];
    assign w_rt = i_ir[20:16];
    assign w_fn = i_ir[5:0];
    // rs and the immediate/shift fields do not affect control decisions
    assign w_unused_fields = ^{i_ir[25:21], i_ir[15:6]};

    always_comb begin
        o_alu_func  = 6'b000000;
        o_class     = CLS_ALU;
        o_src_imm   = 1'b0;
        o_regdst_rd = 1'b0;
        o_illegal   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_regdst_rd = 1'b1;
                case (w_fn)
                    F_ADD:  o_alu_func = ALU_ADD;
                    F_ADDU: o_alu_func = ALU_ADDU;
                    F_SUB:  o_alu_func = ALU_SUB;
                    F_SUBU: o_alu_func = ALU_SUBU;
                    F_AND:  o_alu_func = ALU_AND;
                    F_OR:   o_alu_func = ALU_OR;
                    F_XOR:  o_alu_func = ALU_XOR;
                    F_NOR:  o_alu_func = ALU_NOR;
                    F_SLT:  o_alu_func = ALU_SLT;
                    F_SLTU: o_alu_func = ALU_SLTU;
                    F_JR: begin
                        o_alu_func  = ALU_JR;
                        o_class     = CLS_BRANCH;
                        o_regdst_rd = 1'b0;
                    end
                    default: begin
                        o_illegal   = 1'b1;
                        o_regdst_rd = 1'b0;
                    end
                endcase
            end
            OP_REGIMM: begin
                o_class = CLS_BRANCH;
                if (w_rt == 5'd0)
                    o_alu_func = ALU_BLTZ;
                else if (w_rt == 5'd1)
                    o_alu_func = ALU_BGEZ;
                else
                    o_illegal = 1'b1;
            end
            OP_J:    begin o_alu_func = ALU_J;    o_class = CLS_BRANCH; end
            OP_BEQ:  begin o_alu_func = ALU_BEQ;  o_class = CLS_BRANCH; end
            OP_BNE:  begin o_alu_func = ALU_BNE;  o_class = CLS_BRANCH; end
            OP_BLEZ: begin o_alu_func = ALU_BLEZ; o_class = CLS_BRANCH; end
            OP_BGTZ: begin o_alu_func = ALU_BGTZ; o_class = CLS_BRANCH; end
            OP_ADDI:  begin o_alu_func = ALU_ADD;  o_src_imm = 1'b1; end
            OP_ADDIU: begin o_alu_func = ALU_ADDU; o_src_imm = 1'b1; end
            OP_SLTI:  begin o_alu_func = ALU_SLT;  o_src_imm = 1'b1; end
            OP_SLTIU: begin o_alu_func = ALU_SLTU; o_src_imm = 1'b1; end
            OP_ANDI:  begin o_alu_func = ALU_AND;  o_src_imm = 1'b1; end
            OP_ORI:   begin o_alu_func = ALU_OR;   o_src_imm = 1'b1; end
            OP_XORI:  begin o_alu_func = ALU_XOR;  o_src_imm = 1'b1; end
            OP_LW: begin o_alu_func = ALU_ADD; o_class = CLS_LOAD;  o_src_imm = 1'b1; end
            OP_SW: begin o_alu_func = ALU_ADD; o_class = CLS_STORE; o_src_imm = 1'b1; end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_alu_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory timeout.
// Define MIPS_CTRL_TRAP_EN to make illegal instructions lock the FSM in TRAP until reset.
module mips_alu_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        Clock_in,
    input  logic        Reset_in,
    input  logic [31:0] Instr_in,
    input  logic        Instr_valid_in,
    output logic        Instr_ready_out,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic        Mem_ack_in,
    output logic [5:0]  AluFunc_out,
    output logic        AluSrcImm_out,
    output logic        RegDstRd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        Mem_req_out,
    output logic        Mem_we_out,
    output logic        PcWrite_out,
    output logic        PcSel_out,
    output logic        MemErr_out,
    output logic        Illegal_out,
    output logic [2:0]  State_out
);

    // Counter only has to reach MEM_TIMEOUT-1: the last waiting cycle exits MEM.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ir;
    logic [5:0]       r_alu_func;
    logic             r_src_imm;
    logic             r_regdst;
    iclass_t          r_class;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0]       w_dec_alu;
    iclass_t          w_dec_class;
    logic             w_dec_src_imm;
    logic             w_dec_regdst;
    logic             w_dec_illegal;

    mips_func_decode u_decode (
        .i_ir        (r_ir),
        .o_alu_func  (w_dec_alu),
        .o_class     (w_dec_class),
        .o_src_imm   (w_dec_src_imm),
        .o_regdst_rd (w_dec_regdst),
        .o_illegal   (w_dec_illegal)
    );

    always_ff @(posedge Clock_in or posedge Reset_in) begin
        if (Reset_in)
            r_state <= ST_FETCH;
        else
            r_state <= w_next;
    end

    always_ff @(posedge Clock_in or posedge Reset_in) begin
        if (Reset_in) begin
            r_ir       <= '0;
            r_alu_func <= '0;
            r_src_imm  <= 1'b0;
            r_regdst   <= 1'b0;
            r_class    <= CLS_ALU;
            r_cnt      <= '0;
        end else begin
            if (r_state == ST_FETCH && Instr_valid_in)
                r_ir <= Instr_in;
            if (r_state == ST_DECODE) begin
                r_alu_func <= w_dec_alu;
                r_src_imm  <= w_dec_src_imm;
                r_regdst   <= w_dec_regdst;
                r_class    <= w_dec_class;
            end
            if (r_state == ST_MEM && w_next == ST_MEM)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next          = r_state;
        Instr_ready_out = 1'b0;
        PcWrite_out     = 1'b0;
        PcSel_out       = 1'b0;
        RegWrite_out    = 1'b0;
        MemToReg_out    = 1'b0;
        Mem_req_out     = 1'b0;
        Mem_we_out      = 1'b0;
        MemErr_out      = 1'b0;
        Illegal_out     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                Instr_ready_out = 1'b1;
                if (Instr_valid_in) begin
                    PcWrite_out = 1'b1;
                    w_next      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_dec_illegal) begin
`ifdef MIPS_CTRL_TRAP_EN
                    w_next = ST_TRAP;
`else
                    Illegal_out = 1'b1;
                    w_next      = ST_FETCH;
`endif
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_ALU:    w_next = ST_WB;
                    CLS_LOAD,
                    CLS_STORE:  w_next = ST_MEM;
                    CLS_BRANCH: begin
                        PcWrite_out = Branch_in | Jump_in;
                        PcSel_out   = 1'b1;
                        w_next      = ST_FETCH;
                    end
                    default:    w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                Mem_req_out = 1'b1;
                Mem_we_out  = (r_class == CLS_STORE);
                if (Mem_ack_in) begin
                    w_next = (r_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (TIMEOUT_EN && r_cnt == CNT_LAST) begin
                    MemErr_out = 1'b1;
                    w_next     = ST_FETCH;
                end
            end
            ST_WB: begin
                RegWrite_out = 1'b1;
                MemToReg_out = (r_class == CLS_LOAD);
                w_next       = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef MIPS_CTRL_TRAP_EN
                Illegal_out = 1'b1;
                w_next      = ST_TRAP;
`else
                w_next = ST_FETCH;
`endif
            end
            default: w_next = ST_FETCH;
        endcase
    end

    assign AluFunc_out   = r_alu_func;
    assign AluSrcImm_out = r_src_imm;
    assign RegDstRd_out  = r_regdst;
    assign State_out     = r_state;

endmodule

// File: doc/mips_alu_ctrl_fsm.md
Name: mips_alu_ctrl_fsm

Overview:
Multi-cycle control unit for the lab MIPS datapath.
- Fetches one instruction per handshake and decodes it into the 6-bit ALU function code consumed by the ALU.
- Sequences execute, memory and writeback through a state machine.
- Consumes the ALU's branch and jump flags to steer the PC.
- This block produces the ALU function encoding; the ALU consumes it.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for Mem_ack_in in MEM; 0 = wait forever.

Ports:
Clock_in  in  1  rising-edge clock
Reset_in  in  1  asynchronous active-high reset
Instr_in  in  32  instruction word
Instr_valid_in  in  1  instruction source has valid word
Instr_ready_out  out  1  FSM can accept instruction
Branch_in  in  1  ALU branch-taken flag
Jump_in  in  1  ALU jump flag
Mem_ack_in  in  1  data memory completed request
AluFunc_out  out  6  ALU function code
AluSrcImm_out  out  1  1 = ALU B operand is sign-extended immediate
RegDstRd_out  out  1  1 = write rd, 0 = write rt
RegWrite_out  out  1  register file write strobe
MemToReg_out  out  1  writeback data from memory
Mem_req_out  out  1  memory request held until ack
Mem_we_out  out  1  1 = store, 0 = load (valid with Mem_req_out)
PcWrite_out  out  1  PC update strobe
PcSel_out  out  1  0 = PC+4, 1 = ALU/branch target
MemErr_out  out  1  one-cycle pulse on memory timeout
Illegal_out  out  1  undecodable instruction seen
State_out  out  3  current state, for debug

Behaviour:
- Clock and reset: single clock Clock_in. Reset_in is asynchronous, active-high.
- Reset state: FSM enters FETCH. Reset also clears the instruction register (IR), AluFunc_out and the timeout counter.
- Reset values of outputs:
  - Instr_ready_out = 1 (it is high in FETCH).
  - State_out = 0 (the FETCH encoding).
  - All other outputs = 0.
- Reset mid-operation aborts any in-flight memory request immediately, with no writeback.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - Instr_ready_out = 1.
  - On Instr_valid_in & ready: latch IR, pulse PcWrite_out with PcSel_out = 0, go to DECODE.
- DECODE (1 cycle): register AluFunc_out, AluSrcImm_out, RegDstRd_out and the instruction class.
- Opcode 0 (R-type), by funct:
  - funct 100000..100111, 101010, 101011 pass through unchanged as the ALU code.
  - JR (funct 001000) maps to 111011.
- I-type mappings:
  - ADDI -> 100000, ADDIU -> 100001.
  - SLTI -> 101010, SLTIU -> 101011.
  - ANDI -> 100100, ORI -> 100101, XORI -> 100110.
  - LW and SW -> 100000.
  - BEQ -> 111100, BNE -> 111101, BLEZ -> 111110, BGTZ -> 111111.
  - REGIMM with rt = 0 (BLTZ) -> 111000; rt = 1 (BGEZ) -> 111001.
  - J -> 111010.
- Any other opcode/funct is illegal.
- EXEC (1 cycle): AluFunc_out is held, then:
  - ALU class: go to WB.
  - LW/SW: go to MEM.
  - Branch/jump: PcWrite_out = Branch_in | Jump_in, PcSel_out = 1, go to FETCH.
- MEM:
  - Mem_req_out = 1; Mem_we_out = 1 for SW.
  - On Mem_ack_in: SW goes to FETCH, LW goes to WB.
  - An ack in the first MEM cycle is legal.
  - Timeout counter counts MEM cycles without ack. When it reaches MEM_TIMEOUT (nonzero): drop the request, pulse MemErr_out, go to FETCH, no writeback.
- WB (1 cycle):
  - RegWrite_out = 1.
  - MemToReg_out = 1 for LW.
  - RegDstRd_out = 1 for R-type.
  - Then go to FETCH.
- Writes to register 0 are still strobed; the register file ignores them.
- AluFunc_out holds its value from DECODE until the next DECODE.
- Throughput: 3 cycles for branch/jump, 4 for ALU ops, 4 + memory wait for SW, 5 + memory wait for LW.

Optional Feature:
MIPS_CTRL_TRAP_EN
- Defined: an illegal instruction goes to TRAP. TRAP sets Illegal_out = 1 (sticky), Instr_ready_out = 0, and makes no writes. Only reset leaves TRAP.
- Undefined: an illegal instruction is a NOP. Illegal_out pulses for 1 cycle in DECODE, then the FSM returns to FETCH with no writes. TRAP is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum/localparams;
  - opcode and funct constants;
  - the 6-bit ALU function code constants (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, BLTZ, BGEZ, J, JR, BEQ, BNE, BLEZ, BGTZ);
  - the instruction class enum.
- One sub-module: mips_func_decode. It is purely combinational: IR in; ALU code, class, imm/regdst selects and illegal flag out. The FSM registers its outputs in DECODE.

Test Plan:
- ADD: Instr 0x012A4020 (add $8,$9,$10) -> AluFunc_out = 100000 from DECODE on; 1-cycle RegWrite_out with RegDstRd_out = 1 in WB; back in FETCH 4 cycles after accept.
- BEQ taken: opcode 000100 with Branch_in = 1 in EXEC -> AluFunc_out = 111100; PcWrite_out = 1 and PcSel_out = 1 for one cycle; no RegWrite_out. With Branch_in = 0 -> no EXEC PC write.
- LW: Mem_ack_in 3 cycles after entering MEM -> Mem_req_out held 3 cycles with Mem_we_out = 0; then WB with MemToReg_out = 1 and RegDstRd_out = 0.
- Timeout: MEM_TIMEOUT = 4, SW, no ack -> Mem_req_out high 4 cycles; MemErr_out pulses; FETCH with no writeback.
- Reset in MEM: Reset_in asserted mid-request -> Mem_req_out = 0 and State_out = 0 without a clock edge.
- Illegal opcode 111111 -> with MIPS_CTRL_TRAP_EN: Illegal_out sticky, Instr_ready_out = 0. Without it: 1-cycle Illegal_out pulse, then FETCH.
